// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Dual-width instruction buffer between fetch and decode. Accepts up to two
//   fetched instructions per cycle and squeezes out an invalid first slot.
//   Presents the two oldest entries to decode, which retires 0, 1 or 2 of them.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   flush               synchronous clear of every entry (redirect)
//   in_I1*/in_I2*       fetched pair: instruction, valid, predicted-taken, PC
//   stall               to fetch; high while fewer than two slots are free
//   out_I1*/out_I2*     head and head+1 entries, valid when present
//   take1/take2         decode consumes head / head and head+1
//   count               current occupancy
//   stall_cycles        saturating count of stalled cycles (FDQ_STALL_STATS_EN)
//
// Optional feature macro: FDQ_STALL_STATS_EN
module fetch_decode_queue #(
  parameter int DEPTH = 8,
  parameter int IW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [IW-1:0]          in_I1,
  input  logic                   in_I1V,
  input  logic                   in_I1P,
  input  logic [IW-1:0]          in_I1PC,
  input  logic [IW-1:0]          in_I2,
  input  logic                   in_I2V,
  input  logic                   in_I2P,
  input  logic [IW-1:0]          in_I2PC,
  output logic                   stall,
  output logic [IW-1:0]          out_I1,
  output logic                   out_I1P,
  output logic [IW-1:0]          out_I1PC,
  output logic                   out_I1V,
  output logic [IW-1:0]          out_I2,
  output logic                   out_I2P,
  output logic [IW-1:0]          out_I2PC,
  output logic                   out_I2V,
  input  logic                   take1,
  input  logic                   take2,
`ifdef FDQ_STALL_STATS_EN
  output logic [15:0]            stall_cycles,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] instrMem [DEPTH];
  logic          predMem  [DEPTH];
  logic [IW-1:0] pcMem    [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          enq;
  logic [1:0]    nIn;
  logic [1:0]    nReq;
  logic [1:0]    nOut;
  logic [1:0]    nEnq;
  logic [PW-1:0] i2Slot;
  logic [PW-1:0] headPlus1;

  // Stall looks only at the registered count, so a take in the same cycle
  // never opens room early.
  assign stall = count_q > CW'(DEPTH - 2);
  assign enq   = !stall && !flush;

  // A lone I2 lands at tail so the queue never holds a hole.
  assign i2Slot    = in_I1V ? tail_q + PW'(1) : tail_q;
  assign headPlus1 = head_q + PW'(1);

  // Next-state pointers and occupancy; takes beyond what is present are
  // clamped, and take2 without take1 counts as no take.
  always_comb begin
    nIn  = {1'b0, in_I1V} + {1'b0, in_I2V};
    nEnq = enq ? nIn : 2'd0;
    nReq = 2'd0;
    if (take1) begin
      nReq = take2 ? 2'd2 : 2'd1;
    end
    nOut = nReq;
    if (count_q < CW'(nReq)) begin
      nOut = count_q[1:0];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(nOut);
      tail_d  = tail_q + PW'(nEnq);
      count_d = count_q - CW'(nOut) + CW'(nEnq);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (enq) begin
      if (in_I1V) begin
        instrMem[tail_q] <= in_I1;
        predMem[tail_q]  <= in_I1P;
        pcMem[tail_q]    <= in_I1PC;
      end
      if (in_I2V) begin
        instrMem[i2Slot] <= in_I2;
        predMem[i2Slot]  <= in_I2P;
        pcMem[i2Slot]    <= in_I2PC;
      end
    end
  end

  assign out_I1   = instrMem[head_q];
  assign out_I1P  = predMem[head_q];
  assign out_I1PC = pcMem[head_q];
  assign out_I1V  = count_q != '0;
  assign out_I2   = instrMem[headPlus1];
  assign out_I2P  = predMem[headPlus1];
  assign out_I2PC = pcMem[headPlus1];
  assign out_I2V  = count_q >= CW'(2);
  assign count    = count_q;

`ifdef FDQ_STALL_STATS_EN
  logic [15:0] stallCycles_q;

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCycles_q <= '0;
    end else if (stall && !flush && stallCycles_q != 16'hFFFF) begin
      stallCycles_q <= stallCycles_q + 16'd1;
    end
  end

  assign stall_cycles = stallCycles_q;
`endif

  // Stall keeps two slots free whenever enqueue is allowed.
  assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue
//   Randomised and directed stimulus for fetch_decode_queue. A reference
//   model keeps the expected contents as a plain queue of entries; a monitor
//   compares every presented output against it at the falling edge.
module tb_fetch_decode_queue;

  localparam int DEPTH = 8;
  localparam int IW    = 16;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic          pred;
    logic [IW-1:0] pc;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [IW-1:0] in_I1, in_I1PC, in_I2, in_I2PC;
  logic          in_I1V, in_I1P, in_I2V, in_I2P;
  logic          stall;
  logic [IW-1:0] out_I1, out_I1PC, out_I2, out_I2PC;
  logic          out_I1P, out_I1V, out_I2P, out_I2V;
  logic          take1, take2;
  logic [$clog2(DEPTH):0] count;
`ifdef FDQ_STALL_STATS_EN
  logic [15:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int protoNotes = 0;

  entry_t      modelQ[$];
  logic [15:0] statModel = 16'd0;

  fetch_decode_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_I1(in_I1), .in_I1V(in_I1V), .in_I1P(in_I1P), .in_I1PC(in_I1PC),
    .in_I2(in_I2), .in_I2V(in_I2V), .in_I2P(in_I2P), .in_I2PC(in_I2PC),
    .stall(stall),
    .out_I1(out_I1), .out_I1P(out_I1P), .out_I1PC(out_I1PC), .out_I1V(out_I1V),
    .out_I2(out_I2), .out_I2P(out_I2P), .out_I2PC(out_I2PC), .out_I2V(out_I2V),
    .take1(take1), .take2(take2),
`ifdef FDQ_STALL_STATS_EN
    .stall_cycles(stall_cycles),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of fetch/decode/flush inputs, then settle past the edge.
  task automatic applyStimulus(input logic v1, input logic [IW-1:0] i1, input logic p1,
                               input logic [IW-1:0] pc1, input logic v2,
                               input logic [IW-1:0] i2, input logic p2,
                               input logic [IW-1:0] pc2, input logic t1,
                               input logic t2, input logic fl);
    in_I1V = v1; in_I1 = i1; in_I1P = p1; in_I1PC = pc1;
    in_I2V = v2; in_I2 = i2; in_I2P = p2; in_I2PC = pc2;
    take1 = t1; take2 = t2; flush = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO of entries updated from the rules at each edge.
  int     mAvail;
  int     mOut;
  logic   mStall;
  entry_t mEntry;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelQ.delete();
      statModel = 16'd0;
    end else begin
      mAvail = modelQ.size();
      mStall = (DEPTH - mAvail) < 2;
      if (mStall && !flush && statModel != 16'hFFFF) statModel = statModel + 16'd1;
      if (flush) begin
        modelQ.delete();
      end else begin
        mOut = take1 ? (take2 ? 2 : 1) : 0;
        if (mOut > mAvail) begin
          protoNotes++;
          mOut = mAvail;
        end
        repeat (mOut) mEntry = modelQ.pop_front();
        if (!mStall) begin
          if (in_I1V) modelQ.push_back('{instr: in_I1, pred: in_I1P, pc: in_I1PC});
          if (in_I2V) modelQ.push_back('{instr: in_I2, pred: in_I2P, pc: in_I2PC});
        end
      end
    end
  end

  // Monitor: compare occupancy and every presented entry against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("count", 32'(count), 32'(modelQ.size()));
      checkOutput("stall", 32'(stall), 32'((DEPTH - modelQ.size()) < 2));
      checkOutput("out_I1V", 32'(out_I1V), 32'(modelQ.size() >= 1));
      checkOutput("out_I2V", 32'(out_I2V), 32'(modelQ.size() >= 2));
      if (modelQ.size() >= 1) begin
        checkOutput("out_I1", 32'(out_I1), 32'(modelQ[0].instr));
        checkOutput("out_I1P", 32'(out_I1P), 32'(modelQ[0].pred));
        checkOutput("out_I1PC", 32'(out_I1PC), 32'(modelQ[0].pc));
      end
      if (modelQ.size() >= 2) begin
        checkOutput("out_I2", 32'(out_I2), 32'(modelQ[1].instr));
        checkOutput("out_I2P", 32'(out_I2P), 32'(modelQ[1].pred));
        checkOutput("out_I2PC", 32'(out_I2PC), 32'(modelQ[1].pc));
      end
`ifdef FDQ_STALL_STATS_EN
      checkOutput("stall_cycles", 32'(stall_cycles), 32'(statModel));
`endif
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0; take1 = 1'b0; take2 = 1'b0;
    in_I1V = 1'b0; in_I1 = '0; in_I1P = 1'b0; in_I1PC = '0;
    in_I2V = 1'b0; in_I2 = '0; in_I2P = 1'b0; in_I2PC = '0;
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_I1V", 32'(out_I1V), 32'd0);
    checkOutput("rst_I2V", 32'(out_I2V), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full pair into an empty queue.
    applyStimulus(1, 16'h1111, 0, 16'h0000, 1, 16'h2222, 0, 16'h0002, 0, 0, 0);
    checkOutput("tp1_count", 32'(count), 32'd2);
    checkOutput("tp1_I1", 32'(out_I1), 32'h1111);
    checkOutput("tp1_I2", 32'(out_I2), 32'h2222);
    checkOutput("tp1_I2PC", 32'(out_I2PC), 32'h0002);
    checkOutput("tp1_I1V", 32'(out_I1V), 32'd1);
    checkOutput("tp1_I2V", 32'(out_I2V), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Lone I2 is compacted into the head slot.
    applyStimulus(0, 16'h0BAD, 0, 16'h0000, 1, 16'hABCD, 1, 16'h0010, 0, 0, 0);
    checkOutput("tp2_count", 32'(count), 32'd1);
    checkOutput("tp2_I1", 32'(out_I1), 32'hABCD);
    checkOutput("tp2_I1P", 32'(out_I1P), 32'd1);
    checkOutput("tp2_I2V", 32'(out_I2V), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Fill to DEPTH with pairs, then hold a fifth pair while stalled.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 16'(16'h3000 + 2 * k), 0, 16'(4 * k),
                    1, 16'(16'h3001 + 2 * k), 1, 16'(4 * k + 2), 0, 0, 0);
      checkOutput("tp3_count", 32'(count), 32'(2 * (k + 1)));
      checkOutput("tp3_stall", 32'(stall), 32'(k == 3));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 16'h3008, 0, 16'h0010, 1, 16'h3009, 0, 16'h0012, 0, 0, 0);
      checkOutput("tp3_hold_count", 32'(count), 32'd8);
      checkOutput("tp3_hold_stall", 32'(stall), 32'd1);
    end

    // Double take from full: stall drops, then the held pair goes in.
    applyStimulus(1, 16'h3008, 0, 16'h0010, 1, 16'h3009, 0, 16'h0012, 1, 1, 0);
    checkOutput("tp4_count", 32'(count), 32'd6);
    checkOutput("tp4_stall", 32'(stall), 32'd0);
    checkOutput("tp4_I1PC", 32'(out_I1PC), 32'h0004);
    applyStimulus(1, 16'h3008, 0, 16'h0010, 1, 16'h3009, 0, 16'h0012, 0, 0, 0);
    checkOutput("tp4_refill", 32'(count), 32'd8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Streaming pairs with double takes wraps the pointers.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 16'(16'h5000 + 2 * k), 0, 16'(4 * k),
                    1, 16'(16'h5001 + 2 * k), 0, 16'(4 * k + 2), 1, 1, 0);
      checkOutput("tp5_count", 32'(count), 32'd2);
      checkOutput("tp5_I1PC", 32'(out_I1PC), 32'(4 * k));
      checkOutput("tp5_I2PC", 32'(out_I2PC), 32'(4 * k + 2));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Flush wins over a concurrent enqueue and take.
    applyStimulus(1, 16'h6000, 0, 16'h0100, 1, 16'h6001, 0, 16'h0102, 0, 0, 0);
    applyStimulus(1, 16'h6002, 0, 16'h0104, 1, 16'h6003, 0, 16'h0106, 0, 0, 0);
    applyStimulus(1, 16'h6004, 1, 16'h0108, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
    checkOutput("tp6_count5", 32'(count), 32'd5);
    applyStimulus(1, 16'h6005, 0, 16'h010A, 1, 16'h6006, 0, 16'h010C, 1, 0, 1);
    checkOutput("tp6_count", 32'(count), 32'd0);
    checkOutput("tp6_I1V", 32'(out_I1V), 32'd0);
`ifdef FDQ_STALL_STATS_EN
    checkOutput("tp6_stall_cycles", 32'(stall_cycles), 32'd4);
`endif

    // Random traffic, including stale takes and occasional flushes.
    for (int n = 0; n < 1500; n++) begin
      logic t1, t2;
      t1 = ($urandom_range(0, 9) < 5);
      t2 = ($urandom_range(0, 9) < 6);
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                    16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                    1'($urandom_range(0, 1)), 16'($urandom), t1, t2,
                    ($urandom_range(0, 49) == 0));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] takes beyond available entries (protocol errors, clamped): %0d", protoNotes);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Dual-width instruction buffer between the fetch stage and the decode stage.
- Each cycle it accepts up to two fetched instructions with their PC and prediction bits, and compacts out any invalid slot.
- Each cycle it presents the two oldest entries to decode, and decode retires 0, 1 or 2 of them.
- It drives the fetch-stage stall when it cannot guarantee room for a full pair, and empties on pipeline flush.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- IW, 16, instruction and PC width.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries (mispredict / redirect).
- in_I1  in  IW  first fetched instruction.
- in_I1V  in  1  in_I1 valid.
- in_I1P  in  1  in_I1 predicted-taken bit.
- in_I1PC  in  IW  in_I1 PC.
- in_I2  in  IW  second fetched instruction.
- in_I2V  in  1  in_I2 valid.
- in_I2P  in  1  in_I2 predicted-taken bit.
- in_I2PC  in  IW  in_I2 PC.
- stall  out  1  to fetch; high when free slots < 2.
- out_I1, out_I1P, out_I1PC  out  IW/1/IW  head entry fields.
- out_I1V  out  1  head entry present (count >= 1).
- out_I2, out_I2P, out_I2PC  out  IW/1/IW  head+1 entry fields.
- out_I2V  out  1  head+1 entry present (count >= 2).
- take1  in  1  decode consumes the head entry this cycle.
- take2  in  1  decode consumes head+1 as well; legal only with take1.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular array of {instr, pred, pc}; head and tail pointers of width $clog2(DEPTH) wrap modulo DEPTH; separate occupancy counter.
- Reset (rst high, async): head = tail = count = 0, stall = 0, all out_*V = 0. Entry contents are don't-care.
- stall = (DEPTH - count) < 2, combinational from the registered count; decode takes in the same cycle are not credited.
- Enqueue happens only at a posedge where stall = 0 and flush = 0. The fetch stage holds its outputs while stalled, so a held pair is never written twice.
- Enqueue count n_in = in_I1V + in_I2V.
  - Both valid: I1 written at tail, I2 at tail+1.
  - Only in_I2V set: I2 written at tail (compaction).
  - Only in_I1V set: I1 written at tail.
  - tail advances by n_in.
- Dequeue count n_out: 0 if !take1, 1 if take1 & !take2, 2 if take1 & take2.
- take1 with out_I1V = 0, or take2 with out_I2V = 0: ignored and clamped to the available count, never underflow. Bench flags these as a protocol error.
- take2 without take1: treated as no take.
- Dequeue may coincide with enqueue: count_next = count + n_in - n_out.
- Outputs are read combinationally from the head slots. An entry enqueued at edge t is visible on out_* after edge t (latency 1 cycle).
- Enqueue into an empty queue concurrent with a take of stale outputs: the take is clamped to 0 because count is 0.
- Fields of an out_*V = 0 slot are don't-care; the bench must not compare them.
- flush: at posedge, head = tail = count = 0; the concurrent enqueue and dequeue are discarded. rst takes priority over flush.
- Order: program order is preserved across wrap. I1 is always older than I2 of the same pair.
- Overflow is impossible by construction: stall guarantees >= 2 free slots whenever enqueue is permitted. An assertion flags count > DEPTH.

Optional Feature:
- Macro FDQ_STALL_STATS_EN.
- Defined:
  - Adds output stall_cycles (16 bits).
  - Increments on every posedge where stall = 1 and flush = 0.
  - Saturates at 16'hFFFF.
  - Cleared by rst only; flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then pair {0x1111 @ PC 0x0000, 0x2222 @ PC 0x0002} both valid, no take -> next cycle count = 2, out_I1 = 0x1111, out_I2 = 0x2222, out_I2PC = 0x0002, both V = 1.
- in_I1V = 0, in_I2V = 1, in_I2 = 0xABCD, in_I2P = 1 into empty queue -> count = 1, out_I1 = 0xABCD, out_I1P = 1, out_I2V = 0.
- DEPTH = 8, four valid pairs back-to-back, no take -> stall low through count 6, count = 8 after the 4th, stall = 1; a 5th pair held for 3 cycles is not written.
- Full queue with take1 & take2 and a held pair present -> count 8 -> 6, stall drops next cycle; the pair is enqueued on the following edge, count = 8.
- Continuous pair enqueue with take1 & take2 for 10 cycles -> pointers wrap; outputs match PC order 0x0000, 0x0002, ..., count stays 2.
- count = 5 with flush and a valid pair and take1 all in the same cycle -> count = 0, out_I1V = 0; with FDQ_STALL_STATS_EN the stall_cycles value is retained.
